serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse, sampled only in state IDLE.
REQ-005 a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  single-cycle result-valid strobe.
REQ-009 diff  output  WIDTH  result, (a - b) mod 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; equals 1 iff a < b as unsigned values.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 Transitions: IDLE->RUN on start=1; RUN->DONE after the WIDTH-th bit step; DONE->IDLE unconditionally after one cycle.
REQ-013 On acceptance, the block SHALL:
- latch a and b into internal shift registers;
- clear the bit counter;
- clear the internal borrow.
REQ-014 In RUN, each clock edge SHALL process exactly one bit, LSB first, using a full-subtractor cell:
- d = ai ^ bi ^ bin;
- bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-015 Each d bit SHALL be shifted into the result register from the MSB side, so that diff is bit-aligned when DONE is reached.
REQ-016 Latency: if start is accepted at edge k, the last bit SHALL be processed at edge k+WIDTH, and done SHALL be high for exactly the cycle following that edge.
REQ-017 diff and borrow_out SHALL update only at the transition into DONE, and SHALL hold until the next transition into DONE or until reset; intermediate shift contents SHALL NOT be visible on diff.
REQ-018 start SHALL be ignored while busy=1; a and b SHALL NOT be re-sampled in RUN or DONE.
REQ-019 start asserted in the IDLE cycle immediately following DONE SHALL be accepted, giving back-to-back operations every WIDTH+2 cycles.
REQ-020 The bit counter SHALL be wide enough to hold WIDTH-1 and SHALL NOT wrap within one operation.
REQ-021 The outputs of a, b and borrow SHALL be treated as unsigned; no sign extension SHALL be performed.

Reset
REQ-022 While rst=1 at a clock edge:
- the state SHALL go to IDLE;
- busy, done, diff, borrow_out, the counter, the internal borrow and both shift registers SHALL be cleared to 0.
REQ-023 rst SHALL take priority over start and over any in-progress operation; an operation aborted mid-RUN SHALL produce no done pulse, and diff SHALL read 0.
REQ-024 The first start SHALL be accepted at the edge following the deassertion of rst.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-026 The per-bit arithmetic SHALL be a combinational sub-module fs_bh (inputs a, b, b_in; outputs d, b_out), instantiated once.
REQ-027 The sequencing (FSM, counter, shift registers) SHALL reside in serial_sub.

Verification
REQ-028 WIDTH=8, a=8'd5, b=8'd3, start pulse -> done exactly 8 edges after the acceptance edge, diff=8'h02, borrow_out=0.
REQ-029 a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1.
REQ-030 a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1; a=8'hA5, b=8'hA5 -> diff=8'h00, borrow_out=0.
REQ-031 Mid-RUN, start=1 with a=8'hFF, b=8'h00 -> ignored; the result SHALL be that of the originally latched operands.
REQ-032 rst=1 at the 4th RUN edge -> the next cycle shows busy=0, diff=0; no done pulse SHALL occur.
REQ-033 Back-to-back: start held high across DONE -> the second operation SHALL be accepted in IDLE, with done pulses spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand width in bits
//   - state_t       : sequencer state encoding (IDLE / RUN / DONE)
//   - cnt_width()   : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach width-1, so $clog2(width) bits suffice.
  // The floor of 1 keeps the counter a legal vector when width is 2.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// -----------------------------------------------------------------------------
// serial_sub_if
// Request/result bundle of the bit-serial subtractor.
//   start      : request pulse, honoured only while the block is idle
//   a, b       : minuend / subtrahend, captured when start is accepted
//   busy       : high while an operation is running or presenting its result
//   done       : one-cycle result-valid strobe
//   diff       : (a - b) mod 2^WIDTH
//   borrow_out : final borrow, 1 iff a < b (unsigned)
// Modports:
//   master : the requester (drives start/a/b, observes results)
//   slave  : the subtractor
// -----------------------------------------------------------------------------
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_sub_fs_bh.sv
// -----------------------------------------------------------------------------
// fs_bh
// One-bit full subtractor, purely combinational.
//   a     : minuend bit
//   b     : subtrahend bit
//   b_in  : borrow from the less significant bit
//   d     : difference bit
//   b_out : borrow into the more significant bit
// -----------------------------------------------------------------------------
module fs_bh (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d = a ^ b ^ b_in;

  // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when the
  // two bits are equal and a borrow is already pending.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial unsigned subtractor. An accepted request latches a and b, then
// one bit per clock is processed LSB first through a single full-subtractor
// cell. After WIDTH bit steps the result is published on diff/borrow_out and
// done pulses for one cycle, after which the block is idle again.
//
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : synchronous active-high reset, overrides everything
//   bus : serial_sub_if slave modport (start, a, b, busy, done, diff,
//         borrow_out)
//
// Timing, start accepted at edge k:
//   edges k+1 .. k+WIDTH : one bit processed per edge
//   edge  k+WIDTH        : diff/borrow_out updated, state enters DONE
//   cycle after k+WIDTH  : done = 1
//   edge  k+WIDTH+1      : back to IDLE; a new start can be taken at k+WIDTH+2
// -----------------------------------------------------------------------------
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_n;

  logic             accept;     // start taken this cycle
  logic             step;       // one bit processed this cycle
  logic             last_bit;   // current step is the MSB

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;

  // Result bits collected so far. Only WIDTH-1 bits are stored: the bit
  // produced on the final step goes straight into diff alongside them.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             bit_d;
  logic             bit_bout;

  // ---------------------------------------------------------------------------
  // Per-bit arithmetic
  // ---------------------------------------------------------------------------
  fs_bh u_fs_bh (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .b_in  (borrow),
    .d     (bit_d),
    .b_out (bit_bout)
  );

  // New bit enters from the MSB side; after WIDTH steps the first (LSB)
  // result bit has travelled down to bit 0.
  assign res_next = {bit_d, res_sr};
  assign last_bit = (cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments only, so every
  // always_ff block samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case statement,
  // so no path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    step     = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end

      RUN: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (last_bit) begin
          state_n = DONE;
        end
      end

      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_n  = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, counter, running borrow, result registers
  // ---------------------------------------------------------------------------
  // NOTE: the whole datapath is reset, not just the control state, because
  // an aborted operation must leave diff, borrow_out and the shifters at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      borrow   <= 1'b0;
      res_sr   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      cnt    <= '0;
      borrow <= 1'b0;
      res_sr <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bit_bout;
      res_sr <= res_next[WIDTH-1:1];
      if (last_bit) begin
        // Publish only the finished word; partial shifts never reach diff.
        diff_q   <= res_next;
        borrow_q <= bit_bout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
// Self-checking bench for serial_sub (WIDTH = 8). A table of operand pairs
// with their expected results is run first, followed by random operands
// checked against an arithmetic model, then hand-written sequences for
// ignored mid-run starts, reset abort and back-to-back operation. Expected
// results are queued when a request is driven and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int           n_checks = 0;
  int           n_fail   = 0;
  exp_t         sb[$];
  logic [W-1:0] held_diff;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff   = a - b;
    e.borrow = (a < b);
    return e;
  endfunction

  // Waits for done, checking that diff holds its last published value
  // meanwhile, then compares against the scoreboard and checks that done
  // lasts exactly one cycle. stamp is the cycle count when done was seen.
  task automatic wait_done(input string name, output int stamp);
    exp_t e;
    stamp = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        stamp = cyc;
        break;
      end
      check({name, " diff hold"}, 32'(bus.diff), 32'(held_diff));
    end
    if (stamp < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: done not seen within 40 cycles", name);
      return;
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done pulse with no queued expectation", name);
    end else begin
      e = sb.pop_front();
      check({name, " diff"},   32'(bus.diff),       32'(e.diff));
      check({name, " borrow"}, 32'(bus.borrow_out), 32'(e.borrow));
      held_diff = e.diff;
    end
    @(negedge clk);
    check({name, " done width"}, 32'(bus.done), 32'd0);
    check({name, " idle busy"},  32'(bus.busy), 32'd0);
  endtask

  // Single operation with start pulsed for one cycle; checks latency.
  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int acc;
    int stamp;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(e);
    @(negedge clk);
    acc       = cyc;
    bus.start = 1'b0;
    check({name, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(name, stamp);
    if (stamp >= 0) check({name, " latency"}, 32'(stamp - acc), 32'(W));
  endtask

  vec_t vt[7];

  initial begin
    int   acc;
    int   s1;
    int   s2;
    exp_t e;

    vt[0] = '{8'd5,  8'd3,  8'h02, 1'b0};
    vt[1] = '{8'd3,  8'd5,  8'hFE, 1'b1};
    vt[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vt[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vt[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vt[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vt[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    // Reset with start asserted: reset must win.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    held_diff = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   32'(bus.busy),       32'd0);
    check("reset done",   32'(bus.done),       32'd0);
    check("reset diff",   32'(bus.diff),       32'd0);
    check("reset borrow", 32'(bus.borrow_out), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      e.diff   = vt[i].diff;
      e.borrow = vt[i].borrow;
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, e);
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
    end

    // A start raised mid-run with new operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    sb.push_back(model(8'h12, 8'h34));
    @(negedge clk);
    acc       = cyc;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("midrun", s1);
    if (s1 >= 0) check("midrun latency", 32'(s1 - acc), 32'(W));
    repeat (3) @(negedge clk);
    check("midrun no extra op", 32'(bus.busy), 32'd0);

    // Reset on the 4th bit step aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy cleared", 32'(bus.busy),       32'd0);
    check("abort done",         32'(bus.done),       32'd0);
    check("abort diff",         32'(bus.diff),       32'd0);
    check("abort borrow",       32'(bus.borrow_out), 32'd0);
    held_diff = '0;
    // Start offered on the first edge after reset deasserts.
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    sb.push_back(model(8'h44, 8'h11));
    @(negedge clk);
    acc       = cyc;
    bus.start = 1'b0;
    check("post-reset accept", 32'(bus.busy), 32'd1);
    wait_done("post-reset", s1);
    if (s1 >= 0) check("post-reset latency", 32'(s1 - acc), 32'(W));

    // Back-to-back: start held high through DONE; operands changed mid-run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd5;
    bus.b     = 8'd3;
    sb.push_back(model(8'd5, 8'd3));
    @(negedge clk);
    acc   = cyc;
    bus.a = 8'd3;
    bus.b = 8'd5;
    sb.push_back(model(8'd3, 8'd5));
    wait_done("b2b first", s1);
    wait_done("b2b second", s2);
    bus.start = 1'b0;
    if (s1 >= 0) check("b2b first latency", 32'(s1 - acc), 32'(W));
    if (s1 >= 0 && s2 >= 0) check("b2b spacing", 32'(s2 - s1), 32'(W + 2));
    repeat (3) @(negedge clk);
    check("b2b stops", 32'(bus.busy), 32'd0);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
